// File: rtl/ahb_sensor_pkg.sv
// Shared definitions for the S3 sensor slave: bus widths, response codes,
// register offsets, FSM states and STATUS/CTRL field positions.
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 1
`endif

package ahb_sensor_pkg;

   localparam int unsigned DATA_W = `AHB_DATA_BITS;
   localparam int unsigned RESP_W = `AHB_RESP_BITS;

   localparam logic [RESP_W-1:0] RESP_OKAY  = '0;
   localparam logic [RESP_W-1:0] RESP_ERROR = RESP_W'(1);

   // Register offsets, as decoded from HADDR[3:2]
   typedef enum logic [1:0] {
      OFF_DATA    = 2'd0,
      OFF_STATUS  = 2'd1,
      OFF_CTRL    = 2'd2,
      OFF_INT_CLR = 2'd3
   } reg_off_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR1,
      ERR2
   } state_e;

   // STATUS fields
   localparam int unsigned ST_OVF   = 8;
   localparam int unsigned ST_FULL  = 7;
   localparam int unsigned ST_EMPTY = 6;
   localparam int unsigned ST_CNT_W = 6;

   // CTRL fields
   localparam int unsigned CT_EN      = 0;
   localparam int unsigned CT_CLR     = 1;
   localparam int unsigned CT_INT_EN  = 2;
   localparam int unsigned CT_THR_LSB = 8;
   localparam int unsigned CT_THR_W   = 4;

endpackage

// File: rtl/sensor_fifo.sv
// Sample FIFO: power-of-two depth, pointers wrap naturally, synchronous
// reset and flush, combinational head output.
module sensor_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and occupancy tracking; flush has priority over push/pop
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sample storage (no reset needed, validity is tracked by count_q)
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ahb_sensor_slave.sv
// AHB-Lite slave S3: buffers sensor samples and exposes DATA/STATUS/CTRL/
// INT_CLR. Stalls DATA reads on an empty FIFO with a bounded wait, answers
// illegal accesses with a two-cycle ERROR, and raises a level interrupt.
module ahb_sensor_slave
   import ahb_sensor_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned SMP_W    = 32,
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL_S3,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA_S3,
   output logic              HREADY_S3,
   output logic [RESP_W-1:0] HRESP_S3,
   input  logic              sensor_valid,
   input  logic [SMP_W-1:0]  sensor_data,
   output logic              sensor_irq
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned WCW = $clog2(WAIT_MAX + 1);

   state_e                 state_q;
   logic                   hready_q;
   logic [RESP_W-1:0]      hresp_q;
   logic [DATA_W-1:0]      hrdata_q;
   logic [WCW-1:0]         wcnt_q;

   logic                   en_q;
   logic                   int_en_q;
   logic                   clr_q;
   logic [CT_THR_W-1:0]    thr_q;
   logic                   ovf_q;
   logic                   irq_q;
   logic                   wr_pend_q;
   reg_off_e               wr_off_q;

   logic [SMP_W-1:0]       f_dout;
   logic [CW-1:0]          f_count;
   logic                   f_full;
   logic                   f_empty;
   logic                   f_push;
   logic                   f_pop;

   reg_off_e               addr_off;
   logic                   accept;
   logic                   illegal;
   logic                   rd_stall;
   logic                   rd_pop;
   logic                   push_ok;
   logic                   bypass;
   logic [ST_CNT_W-1:0]    count6;
   logic [DATA_W-1:0]      rd_word;
   logic                   unused_ok;

   assign addr_off  = reg_off_e'(HADDR[3:2]);
   assign accept    = HSEL_S3 & HREADY & HTRANS[1] & ((state_q == IDLE) | (state_q == ERR2));
   assign rd_stall  = ~HWRITE & (addr_off == OFF_DATA) & en_q & f_empty;
   assign rd_pop    = ~HWRITE & (addr_off == OFF_DATA) & en_q & ~f_empty;
   assign push_ok   = sensor_valid & en_q & ~f_full;
   assign count6    = ST_CNT_W'(f_count);
   assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

   // A sample arriving while a read is stalled on an empty FIFO goes straight
   // to HRDATA instead of being pushed and popped.
   assign bypass = (state_q == WAIT) & f_empty;
   assign f_push = push_ok & ~bypass;

   // The head is captured into HRDATA at the address phase, so it is popped
   // there too; this keeps back-to-back DATA reads returning successive samples.
   assign f_pop = (accept & rd_pop) | ((state_q == WAIT) & ~f_empty);

   // Illegal access decode for the current address phase
   always_comb begin
      illegal = 1'b0;
      if (HWRITE) illegal = (addr_off == OFF_DATA) || (addr_off == OFF_STATUS);
      else        illegal = (addr_off == OFF_INT_CLR) || ((addr_off == OFF_DATA) && !en_q);
   end

   // Read data mux for zero-wait reads
   always_comb begin
      rd_word = '0;
      case (addr_off)
         OFF_DATA: rd_word = DATA_W'(f_dout);
         OFF_STATUS: begin
            rd_word[ST_CNT_W-1:0] = count6;
            rd_word[ST_EMPTY]     = f_empty;
            rd_word[ST_FULL]      = f_full;
            rd_word[ST_OVF]       = ovf_q;
         end
         OFF_CTRL: begin
            rd_word[CT_EN]                      = en_q;
            rd_word[CT_CLR]                     = clr_q;
            rd_word[CT_INT_EN]                  = int_en_q;
            rd_word[CT_THR_LSB +: CT_THR_W]     = thr_q;
         end
         default: rd_word = '0;
      endcase
   end

   // Bus FSM with registered HREADY/HRESP/HRDATA
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= IDLE;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
         hrdata_q <= '0;
         wcnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, ERR2: begin
               state_q  <= IDLE;
               hready_q <= 1'b1;
               hresp_q  <= RESP_OKAY;
               if (accept) begin
                  if (illegal) begin
                     state_q  <= ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= RESP_ERROR;
                     hrdata_q <= '0;
                  end else if (rd_stall) begin
                     state_q  <= WAIT;
                     hready_q <= 1'b0;
                     wcnt_q   <= WCW'(1);
                  end else if (!HWRITE) begin
                     hrdata_q <= rd_word;
                  end
               end
            end
            WAIT: begin
               // Non-empty here only if a sample landed in the stall-entry cycle
               if (!f_empty) begin
                  state_q  <= IDLE;
                  hready_q <= 1'b1;
                  hrdata_q <= DATA_W'(f_dout);
               end else if (push_ok) begin
                  state_q  <= IDLE;
                  hready_q <= 1'b1;
                  hrdata_q <= DATA_W'(sensor_data);
               end else if (wcnt_q == WCW'(WAIT_MAX)) begin
                  state_q <= ERR1;
                  hresp_q <= RESP_ERROR;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            ERR1: begin
               state_q  <= ERR2;
               hready_q <= 1'b1;
               hresp_q  <= RESP_ERROR;
            end
            default: begin
               state_q  <= IDLE;
               hready_q <= 1'b1;
               hresp_q  <= RESP_OKAY;
            end
         endcase
      end
   end

   // CTRL/INT_CLR writes land at the end of the data phase; ovf and irq tracking
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         en_q      <= 1'b0;
         int_en_q  <= 1'b0;
         clr_q     <= 1'b0;
         thr_q     <= '0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_off_q  <= OFF_DATA;
      end else begin
         wr_pend_q <= accept & HWRITE & ~illegal;
         wr_off_q  <= addr_off;
         clr_q     <= 1'b0;
         if (wr_pend_q && (wr_off_q == OFF_CTRL)) begin
            en_q     <= HWDATA[CT_EN];
            int_en_q <= HWDATA[CT_INT_EN];
            clr_q    <= HWDATA[CT_CLR];
            thr_q    <= HWDATA[CT_THR_LSB +: CT_THR_W];
         end
         if (sensor_valid && en_q && f_full && !clr_q)
            ovf_q <= 1'b1;
         else if (wr_pend_q && (wr_off_q == OFF_INT_CLR) && HWDATA[0])
            ovf_q <= 1'b0;
         irq_q <= int_en_q & (ovf_q | ((thr_q != '0) & (count6 >= ST_CNT_W'(thr_q))));
      end
   end

   sensor_fifo #(
      .DEPTH (DEPTH),
      .W     (SMP_W)
   ) u_fifo (
      .clk_i   (HCLK),
      .rst_i   (HRESET),
      .flush_i (clr_q),
      .push_i  (f_push),
      .pop_i   (f_pop),
      .din_i   (sensor_data),
      .dout_o  (f_dout),
      .count_o (f_count),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

   assign HRDATA_S3  = hrdata_q;
   assign HREADY_S3  = hready_q;
   assign HRESP_S3   = hresp_q;
   assign sensor_irq = irq_q;

endmodule
